// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding and default sizes for the programmed-I/O responder
package io_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 8;

  typedef enum logic [1:0] {
    IO_IDLE = 2'd0,
    IO_ACK  = 2'd1,
    IO_DROP = 2'd2
  } io_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count-derived full/empty and combinational head read
module sync_fifo
  import io_pkg::*;
#(
  parameter  int WIDTH = IO_WIDTH,
  parameter  int DEPTH = IO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow locally so a misbehaving caller cannot corrupt state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Storage is not reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - CPU programmed-I/O responder with input and output FIFOs
module io_port_responder
  import io_pkg::*;
#(
  parameter  int WIDTH = IO_WIDTH,
  parameter  int DEPTH = IO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inp_req,
  output logic             inp_ack,
  output logic [WIDTH-1:0] inp_data,
  input  logic             out_req,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ack,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             snk_valid,
  output logic [WIDTH-1:0] snk_data,
  input  logic             snk_ready,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count
);

  io_state_e        inp_state_q;
  io_state_e        out_state_q;
  logic             inp_ack_q;
  logic [WIDTH-1:0] inp_data_q;
  logic             out_ack_q;

  logic             in_full;
  logic             in_empty;
  logic [WIDTH-1:0] in_rdata;
  logic             out_full;
  logic             out_empty;
  logic             src_push;
  logic             cpu_pop;
  logic             cpu_push;
  logic             snk_pop;

  // Full/empty are registered, so a same-cycle push into an empty FIFO cannot satisfy a pop,
  // and a same-cycle sink pop from a full FIFO cannot make room for a CPU push.
  assign src_push = src_valid && !in_full;
  assign cpu_pop  = (inp_state_q == IO_IDLE) && inp_req && !in_empty;
  assign cpu_push = (out_state_q == IO_IDLE) && out_req && !out_full;
  assign snk_pop  = snk_ready && !out_empty;

  assign src_ready = !in_full;
  assign snk_valid = !out_empty;
  assign inp_ack   = inp_ack_q;
  assign inp_data  = inp_data_q;
  assign out_ack   = out_ack_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (src_push),
    .pop   (cpu_pop),
    .wdata (src_data),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (cpu_push),
    .pop   (snk_pop),
    .wdata (out_data),
    .rdata (snk_data),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // Input handshake: pop one word per request, pulse ack, then wait for the CPU to drop req.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inp_state_q <= IO_IDLE;
      inp_ack_q   <= 1'b0;
      inp_data_q  <= '0;
    end else begin
      case (inp_state_q)
        IO_IDLE: begin
          inp_ack_q <= 1'b0;
          if (cpu_pop) begin
            inp_data_q  <= in_rdata;
            inp_ack_q   <= 1'b1;
            inp_state_q <= IO_ACK;
          end
        end
        IO_ACK: begin
          inp_ack_q   <= 1'b0;
          inp_state_q <= IO_DROP;
        end
        IO_DROP: begin
          inp_ack_q <= 1'b0;
          if (!inp_req) begin
            inp_state_q <= IO_IDLE;
          end
        end
        default: begin
          inp_ack_q   <= 1'b0;
          inp_state_q <= IO_IDLE;
        end
      endcase
    end
  end

  // Output handshake: capture one word per request, pulse ack, then wait for the CPU to drop req.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_state_q <= IO_IDLE;
      out_ack_q   <= 1'b0;
    end else begin
      case (out_state_q)
        IO_IDLE: begin
          out_ack_q <= 1'b0;
          if (cpu_push) begin
            out_ack_q   <= 1'b1;
            out_state_q <= IO_ACK;
          end
        end
        IO_ACK: begin
          out_ack_q   <= 1'b0;
          out_state_q <= IO_DROP;
        end
        IO_DROP: begin
          out_ack_q <= 1'b0;
          if (!out_req) begin
            out_state_q <= IO_IDLE;
          end
        end
        default: begin
          out_ack_q   <= 1'b0;
          out_state_q <= IO_IDLE;
        end
      endcase
    end
  end

endmodule
